// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin scheduler sharing one UART TX serializer among NREQ byte producers
module uart_tx_arb #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int GAP_CLK = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DBIT-1:0]     req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [DBIT-1:0]          tx_din,
  input  logic                     tx_done_tick,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     frame_done
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (GAP_CLK > 1) ? $clog2(GAP_CLK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t          state_q;
  logic [IDW-1:0]  last_q;
  logic [IDW-1:0]  grant_q;
  logic [DBIT-1:0] hold_q;
  logic [CW-1:0]   gap_q;
  logic            start_q;

  logic [IDW-1:0]  win_d;
  logic            win_found_d;
  logic [IDW-1:0]  cand;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_d       = '0;
    win_found_d = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!win_found_d && req_valid[cand]) begin
        win_found_d = 1'b1;
        win_d       = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IDW'(NREQ - 1);
      grant_q <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            hold_q  <= req_data[int'(win_d)*DBIT +: DBIT];
            grant_q <= win_d;
            last_q  <= win_d;
            start_q <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (tx_done_tick) begin
            if (GAP_CLK > 0) begin
              gap_q   <= CW'(GAP_CLK - 1);
              state_q <= S_GAP;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0) state_q <= S_IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE && win_found_d && !rst)
                      ? ({{(NREQ-1){1'b0}}, 1'b1} << win_d) : '0;
  assign tx_start   = start_q;
  assign tx_din     = hold_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;
  assign frame_done = (state_q == S_WAIT) && tx_done_tick && !rst;

endmodule
